// File: rtl/spi_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter_pkg
// Brief    : Shared constants, default parameter values and FSM encoding for
//            the SPI bus arbiter and its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
package spi_bus_arbiter_pkg;

    localparam int c_N_REQ_DEFAULT = 4;
    localparam int c_W_REG_DEFAULT = 32;
    localparam int c_W_SLV_DEFAULT = 3;
    localparam int c_T_WDG_DEFAULT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Width of a requester index; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Round-robin pick: one-hot winner among req, searching from the
//            slot after the previous winner index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import spi_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = c_N_REQ_DEFAULT
) (
    input  logic [N_REQ-1:0]               req,
    input  logic [idx_width(N_REQ)-1:0]    last,
    output logic [N_REQ-1:0]               winner
);

    int w_best;
    int w_dist;

    always_comb begin
        winner = '0;
        w_best = N_REQ;
        w_dist = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // Wrapped distance from the slot just after the previous winner.
            w_dist = (i + 2 * N_REQ - 1 - int'(last)) % N_REQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                winner    = '0;
                winner[i] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Brief    : Round-robin arbiter sharing one SPI master among N_REQ requesters.
//            Optional watchdog abort in WAIT when SPI_ARB_WATCHDOG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = c_N_REQ_DEFAULT,
    parameter int W_REG = c_W_REG_DEFAULT,
    parameter int W_SLV = c_W_SLV_DEFAULT,
    parameter int T_WDG = c_T_WDG_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*W_REG-1:0] req_dat,
    input  logic [N_REQ*W_SLV-1:0] req_slv,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       gnt,
    output logic [W_REG-1:0]       rsp_dat,
    output logic                   err,
    output logic                   spi_go,
    output logic [W_REG-1:0]       spi_dat,
    output logic [W_SLV-1:0]       spi_slv,
    input  logic                   spi_done,
    input  logic [W_REG-1:0]       spi_rdat
);

    localparam int c_IW = idx_width(N_REQ);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_ack;
    logic [c_IW-1:0]   r_last;
    logic [W_REG-1:0]  r_dat;
    logic [W_SLV-1:0]  r_slv;
    logic [W_REG-1:0]  r_rsp_dat;
    logic              r_spi_go;
    logic [N_REQ-1:0]  w_pick;
    logic [c_IW-1:0]   w_pick_idx;
    logic [W_REG-1:0]  w_pick_dat;
    logic [W_SLV-1:0]  w_pick_slv;
    logic              w_timeout;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req),
        .last   (r_last),
        .winner (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        w_pick_dat = '0;
        w_pick_slv = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = c_IW'(i);
                w_pick_dat = req_dat[i*W_REG +: W_REG];
                w_pick_slv = req_slv[i*W_SLV +: W_SLV];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (|req) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_WAIT;
            ST_WAIT:   if (spi_done || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Requester inputs are captured only at grant; the SPI side sees frozen copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_last    <= c_IW'(N_REQ - 1);
            r_dat     <= '0;
            r_slv     <= '0;
            r_rsp_dat <= '0;
            r_spi_go  <= 1'b0;
            r_ack     <= '0;
        end else begin
            r_spi_go <= (r_state == ST_LAUNCH);
            r_ack    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt  <= w_pick;
                        r_last <= w_pick_idx;
                        r_dat  <= w_pick_dat;
                        r_slv  <= w_pick_slv;
                    end
                end
                ST_WAIT: begin
                    if (spi_done) begin
                        r_rsp_dat <= spi_rdat;
                        r_ack     <= r_gnt;
                    end else if (w_timeout) begin
                        r_rsp_dat <= '1;
                        r_ack     <= r_gnt;
                    end
                end
                ST_DONE: r_gnt <= '0;
                default: ;
            endcase
        end
    end

`ifdef SPI_ARB_WATCHDOG_EN
    localparam int c_CW = $clog2(T_WDG + 1);

    logic [c_CW-1:0] r_wdg_cnt;
    logic            r_err;

    // Counter is zero in the first WAIT cycle, so abort lands T_WDG+1 cycles after spi_go.
    assign w_timeout = (r_state == ST_WAIT) && !spi_done && (r_wdg_cnt == c_CW'(T_WDG));

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAIT)) r_wdg_cnt <= '0;
        else                             r_wdg_cnt <= r_wdg_cnt + c_CW'(1);
        if (rst) r_err <= 1'b0;
        else     r_err <= w_timeout;
    end

    assign err = r_err;
`else
    logic w_unused_wdg;

    assign w_timeout    = 1'b0;
    assign w_unused_wdg = (T_WDG > 0);
    assign err          = 1'b0;
`endif

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign rsp_dat = r_rsp_dat;
    assign spi_go  = r_spi_go;
    assign spi_dat = r_dat;
    assign spi_slv = r_slv;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_arbiter
// Brief    : Self-checking bench for spi_bus_arbiter with a round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int S   = 3;
    localparam int WDG = 16;
    // Inputs are driven just after a rising edge; spi_go two rising edges
    // later is seen on the third falling edge after the drive.
    localparam int c_GO_LAT = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_dat;
    logic [N*S-1:0] req_slv;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic [W-1:0]   rsp_dat;
    logic           err;
    logic           spi_go;
    logic [W-1:0]   spi_dat;
    logic [S-1:0]   spi_slv;
    logic           spi_done;
    logic [W-1:0]   spi_rdat;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_dat [N];
    logic [S-1:0] m_slv [N];
    logic [W-1:0] m_rsp;

    always #5 clk = ~clk;

    spi_bus_arbiter #(
        .N_REQ (N),
        .W_REG (W),
        .W_SLV (S),
        .T_WDG (WDG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_dat  (req_dat),
        .req_slv  (req_slv),
        .ack      (ack),
        .gnt      (gnt),
        .rsp_dat  (rsp_dat),
        .err      (err),
        .spi_go   (spi_go),
        .spi_dat  (spi_dat),
        .spi_slv  (spi_slv),
        .spi_done (spi_done),
        .spi_rdat (spi_rdat)
    );

    task automatic drive_reqs(input logic [N-1:0] r);
        req = r;
        for (int i = 0; i < N; i++) begin
            req_dat[i*W +: W] = m_dat[i];
            req_slv[i*S +: S] = m_slv[i];
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = '0; spi_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_rsp = '0;
    endtask

    // Plays the SPI master for one transfer and records what the arbiter showed.
    task automatic serve(input logic [W-1:0] rdat, input int delay, input bit scramble,
                         output bit ok, output int lat, output logic go2,
                         output logic [N-1:0] g, output logic [W-1:0] sdat,
                         output logic [S-1:0] sslv, output logic [N-1:0] a,
                         output logic [W-1:0] rsp, output logic [W-1:0] sdat_end);
        ok = 1'b0; lat = 0; go2 = 1'b1; g = '0; sdat = '0; sslv = '0;
        a = '0; rsp = '0; sdat_end = '0;
        for (int k = 1; k <= 20 && !ok; k++) begin
            @(negedge clk);
            if (spi_go === 1'b1) begin
                ok = 1'b1; lat = k; g = gnt; sdat = spi_dat; sslv = spi_slv;
            end
        end
        if (!ok) return;
        @(negedge clk);
        go2 = spi_go;
        repeat (delay) @(posedge clk);
        @(posedge clk); #1;
        if (scramble) begin
            req_dat = {$urandom, $urandom, $urandom, $urandom};
            req_slv = 12'($urandom);
        end
        spi_done = 1'b1; spi_rdat = rdat;
        @(posedge clk); #1;
        spi_done = 1'b0; spi_rdat = $urandom;
        @(negedge clk);
        a = ack; rsp = rsp_dat; sdat_end = spi_dat;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt !== '0)     begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
        checks++; if (ack !== '0)     begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (spi_go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b expected 0", spi_go); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (rsp_dat !== '0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", rsp_dat); end
        checks++; if ({spi_dat, spi_slv} !== '0) begin
            errors++; $display("FAIL reset_spi_out: got dat %h slv %0d expected 0", spi_dat, spi_slv);
        end
        @(posedge clk); #1 rst = 1'b0;
        m_rsp = '0;
    endtask

    task automatic test_single();
        bit ok; int lat; logic go2; logic [N-1:0] g, a; logic [W-1:0] sdat, rsp, sdat_end; logic [S-1:0] sslv;
        m_dat[2] = 32'hA5A5_0001; m_slv[2] = 3'd3;
        drive_reqs(4'b0100);
        serve(32'h0000_1234, 2, 1'b0, ok, lat, go2, g, sdat, sslv, a, rsp, sdat_end);
        checks++; if (lat !== c_GO_LAT) begin errors++; $display("FAIL single_go_latency: got %0d expected %0d", lat, c_GO_LAT); end
        checks++; if (go2 !== 1'b0) begin errors++; $display("FAIL single_go_width: spi_go still %b one cycle later", go2); end
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", g); end
        checks++; if (sdat !== 32'hA5A5_0001) begin errors++; $display("FAIL single_spi_dat: got %h expected a5a50001", sdat); end
        checks++; if (sslv !== 3'd3) begin errors++; $display("FAIL single_spi_slv: got %0d expected 3", sslv); end
        checks++; if (a !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", a); end
        checks++; if (rsp !== 32'h0000_1234) begin errors++; $display("FAIL single_rsp: got %h expected 00001234", rsp); end
        m_rsp = 32'h0000_1234;
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        checks++; if ({ack, gnt} !== '0) begin errors++; $display("FAIL single_release: ack %b gnt %b expected 0", ack, gnt); end
    endtask

    task automatic test_all_held();
        bit ok; int lat; logic go2; logic [N-1:0] g, a; logic [W-1:0] sdat, rsp, sdat_end; logic [S-1:0] sslv;
        int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int acks [N];
        logic [N-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_dat[i] = $urandom; m_slv[i] = S'($urandom); acks[i] = 0;
        end
        drive_reqs(4'b1111);
        for (int t = 0; t < 8; t++) begin
            serve($urandom, $urandom_range(2, 0), 1'b0, ok, lat, go2, g, sdat, sslv, a, rsp, sdat_end);
            exp_oh = '0; exp_oh[2'(order[t])] = 1'b1;
            checks++; if (g !== exp_oh) begin errors++; $display("FAIL held_order[%0d]: gnt %b expected %b", t, g, exp_oh); end
            checks++; if (sdat !== m_dat[order[t]]) begin errors++; $display("FAIL held_dat[%0d]: got %h expected %h", t, sdat, m_dat[order[t]]); end
            for (int i = 0; i < N; i++) if (a[i] === 1'b1) acks[i]++;
            m_rsp = rsp;
            @(posedge clk); #1;
        end
        req = '0;
        for (int i = 0; i < N; i++) begin
            checks++; if (acks[i] != 2) begin errors++; $display("FAIL held_ack_count[%0d]: got %0d expected 2", i, acks[i]); end
        end
    endtask

    task automatic test_drop();
        bit ok; int lat; logic go2; logic [N-1:0] g, a; logic [W-1:0] sdat, rsp, sdat_end, rdat; logic [S-1:0] sslv;
        int extra;
        do_reset();
        m_dat[1] = $urandom; m_slv[1] = S'($urandom);
        drive_reqs(4'b0010);
        @(posedge clk);
        @(posedge clk); #1 req = '0;
        rdat = $urandom;
        serve(rdat, 1, 1'b0, ok, lat, go2, g, sdat, sslv, a, rsp, sdat_end);
        checks++; if (!ok) begin errors++; $display("FAIL drop_go: spi_go never seen, got 0 expected 1"); end
        checks++; if (a !== 4'b0010) begin errors++; $display("FAIL drop_ack: got %b expected 0010", a); end
        checks++; if (rsp !== rdat) begin errors++; $display("FAIL drop_rsp: got %h expected %h", rsp, rdat); end
        m_rsp = rdat;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if ((ack !== '0) || (gnt !== '0) || (spi_go !== 1'b0)) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL drop_quiet: %0d busy cycles after ack, expected 0", extra); end
    endtask

    task automatic test_stray_done();
        int bad;
        @(posedge clk); #1;
        spi_done = 1'b1; spi_rdat = ~m_rsp;
        @(posedge clk); #1 spi_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if ((ack !== '0) || (gnt !== '0)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stray_ack: %0d cycles with ack/gnt, expected 0", bad); end
        checks++; if (rsp_dat !== m_rsp) begin errors++; $display("FAIL stray_rsp: got %h expected %h", rsp_dat, m_rsp); end
    endtask

    task automatic test_reset_midflight();
        bit ok; int lat; logic go2; logic [N-1:0] g, a; logic [W-1:0] sdat, rsp, sdat_end, rdat; logic [S-1:0] sslv;
        bit seen;
        do_reset();
        m_dat[2] = $urandom; m_slv[2] = S'($urandom);
        drive_reqs(4'b0100);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (spi_go === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL midrst_go: spi_go never seen, got 0 expected 1"); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++; if ({gnt, ack, spi_go} !== '0) begin
            errors++; $display("FAIL midrst_clear: gnt %b ack %b go %b expected 0", gnt, ack, spi_go);
        end
        checks++; if ({rsp_dat, spi_dat} !== '0) begin
            errors++; $display("FAIL midrst_zero: rsp %h spi_dat %h expected 0", rsp_dat, spi_dat);
        end
        m_dat[0] = $urandom; m_slv[0] = S'($urandom);
        m_dat[3] = $urandom; m_slv[3] = S'($urandom);
        drive_reqs(4'b1001);
        rdat = $urandom;
        serve(rdat, 0, 1'b0, ok, lat, go2, g, sdat, sslv, a, rsp, sdat_end);
        checks++; if (lat !== c_GO_LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, c_GO_LAT); end
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL midrst_winner: got %b expected 0001", g); end
        checks++; if (sdat !== m_dat[0]) begin errors++; $display("FAIL midrst_dat: got %h expected %h", sdat, m_dat[0]); end
        checks++; if (a !== 4'b0001) begin errors++; $display("FAIL midrst_ack: got %b expected 0001", a); end
        m_rsp = rdat;
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_random_rr();
        bit ok; int lat; logic go2; logic [N-1:0] g, a; logic [W-1:0] sdat, rsp, sdat_end, rdat; logic [S-1:0] sslv;
        logic [N-1:0] pend, exp_oh;
        int last, exp_i, won, j;
        int wcnt [N];
        do_reset();
        pend = '0; last = N - 1;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i] = 1'b1; m_dat[i] = $urandom; m_slv[i] = S'($urandom);
                end
            end
            if (pend == '0) begin
                j = $urandom_range(N - 1, 0);
                pend[2'(j)] = 1'b1; m_dat[j] = $urandom; m_slv[j] = S'($urandom);
            end
            drive_reqs(pend);
            // Next owner: first pending requester after the previous winner, wrapping.
            exp_i = -1;
            for (int k = 1; k <= N && exp_i < 0; k++) begin
                j = (last + k) % N;
                if (pend[2'(j)]) exp_i = j;
            end
            exp_oh = '0; exp_oh[2'(exp_i)] = 1'b1;
            rdat = $urandom;
            serve(rdat, $urandom_range(3, 0), 1'b1, ok, lat, go2, g, sdat, sslv, a, rsp, sdat_end);
            checks++; if (lat !== c_GO_LAT) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, lat, c_GO_LAT); end
            checks++; if (go2 !== 1'b0) begin errors++; $display("FAIL rnd_go_width[%0d]: spi_go %b a cycle later", t, go2); end
            checks++; if (g !== exp_oh) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", t, g, exp_oh); end
            checks++; if ({sdat, sslv} !== {m_dat[exp_i], m_slv[exp_i]}) begin
                errors++; $display("FAIL rnd_spi_out[%0d]: got %h/%0d expected %h/%0d", t, sdat, sslv, m_dat[exp_i], m_slv[exp_i]);
            end
            checks++; if (sdat_end !== m_dat[exp_i]) begin errors++; $display("FAIL rnd_dat_stable[%0d]: got %h expected %h", t, sdat_end, m_dat[exp_i]); end
            checks++; if (a !== exp_oh) begin errors++; $display("FAIL rnd_ack[%0d]: got %b expected %b", t, a, exp_oh); end
            checks++; if (rsp !== rdat) begin errors++; $display("FAIL rnd_rsp[%0d]: got %h expected %h", t, rsp, rdat); end
            won = -1;
            for (int i = 0; i < N; i++) if (g[i] === 1'b1) won = i;
            for (int i = 0; i < N; i++) if (pend[i] && (i != won)) wcnt[i]++;
            if (won >= 0) begin
                checks++; if (wcnt[won] > N - 1) begin errors++; $display("FAIL rnd_starve[%0d]: requester %0d waited %0d, limit %0d", t, won, wcnt[won], N - 1); end
                wcnt[won] = 0;
            end
            pend[2'(exp_i)] = 1'b0;
            last = exp_i;
            m_rsp = rdat;
            @(posedge clk); #1;
            drive_reqs(pend);
        end
        req = '0;
        @(negedge clk);
    endtask

`ifdef SPI_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        bit seen; int early;
        do_reset();
        m_dat[3] = $urandom; m_slv[3] = S'($urandom);
        drive_reqs(4'b1000);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (spi_go === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL wdg_go: spi_go never seen, got 0 expected 1"); end
        early = 0;
        for (int k = 1; k < WDG + 1; k++) begin
            @(negedge clk);
            if ((ack !== '0) || (err !== 1'b0)) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL wdg_early: %0d early ack/err cycles, expected 0", early); end
        @(negedge clk);
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wdg_ack: got %b expected 1000", ack); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wdg_err: got %b expected 1", err); end
        checks++; if (rsp_dat !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wdg_rsp: got %h expected ffffffff", rsp_dat); end
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        checks++; if ({ack, err} !== '0) begin errors++; $display("FAIL wdg_pulse: ack %b err %b expected 0", ack, err); end
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; req_dat = '0; req_slv = '0;
        spi_done = 1'b0; spi_rdat = '0; m_rsp = '0;
        for (int i = 0; i < N; i++) begin
            m_dat[i] = '0; m_slv[i] = '0;
        end
        test_reset();
        test_single();
        test_all_held();
        test_drop();
        test_stray_done();
        test_reset_midflight();
        test_random_rr();
`ifdef SPI_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
